// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction fetch block.
package ifetch_pkg;

  localparam int unsigned MEM_DEPTH = 16;
  localparam int unsigned ADDR_W    = 4;
  localparam int unsigned INSTR_W   = 16;
  localparam int unsigned RET_W     = 8;

  localparam logic [INSTR_W-1:0] HALT_WORD = 16'hFFFF;
  localparam logic [ADDR_W-1:0]  LAST_ADDR = ADDR_W'(MEM_DEPTH - 1);

  typedef enum logic [1:0] {
    StIdle,
    StFetch,
    StExec,
    StHalt
  } state_e;

endpackage

// File: rtl/program_memory.sv
// Program store: one synchronous write port, one combinational read port.
module program_memory
  import ifetch_pkg::*;
(
  input  logic               i_clk,
  input  logic               i_we,
  input  logic [ADDR_W-1:0]  i_waddr,
  input  logic [INSTR_W-1:0] i_wdata,
  input  logic [ADDR_W-1:0]  i_raddr,
  output logic [INSTR_W-1:0] o_rdata
);

  logic [INSTR_W-1:0] r_mem [MEM_DEPTH];

  // No reset: contents must survive a block reset.
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch FSM: IDLE -> FETCH -> EXEC -> ... -> HALT, with retired-instruction count.
// Define FETCH_LOOP_EN to wrap pc from 15 back to 0 instead of halting.
module instruction_fetch
  import ifetch_pkg::*;
(
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic               done,
  input  logic               load_en,
  input  logic [ADDR_W-1:0]  load_addr,
  input  logic [INSTR_W-1:0] load_data,
  output logic [INSTR_W-1:0] iin,
  output logic               iin_valid,
  output logic [ADDR_W-1:0]  pc,
  output logic               halted,
  output logic [RET_W-1:0]   retired
);

  state_e             r_state, w_state_next;
  logic [ADDR_W-1:0]  r_pc, w_pc_next;
  logic [INSTR_W-1:0] r_ir, w_ir_next;
  logic [RET_W-1:0]   r_retired, w_retired_next;
  logic [INSTR_W-1:0] w_rdata;
  logic               w_mem_we;

  // Loading is only allowed while the processor is not consuming instructions.
  assign w_mem_we = load_en & ~reset & ((r_state == StIdle) | (r_state == StHalt));

  program_memory u_program_memory (
    .i_clk   (clock),
    .i_we    (w_mem_we),
    .i_waddr (load_addr),
    .i_wdata (load_data),
    .i_raddr (r_pc),
    .o_rdata (w_rdata)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state   <= StIdle;
      r_pc      <= '0;
      r_ir      <= '0;
      r_retired <= '0;
    end else begin
      r_state   <= w_state_next;
      r_pc      <= w_pc_next;
      r_ir      <= w_ir_next;
      r_retired <= w_retired_next;
    end
  end

  always_comb begin
    w_state_next   = r_state;
    w_pc_next      = r_pc;
    w_ir_next      = r_ir;
    w_retired_next = r_retired;
    case (r_state)
      StIdle, StHalt: begin
        if (start) begin
          w_pc_next    = '0;
          w_state_next = StFetch;
        end
      end
      StFetch: begin
        w_ir_next    = w_rdata;
        w_state_next = StExec;
      end
      StExec: begin
        // A halt word wins over a simultaneous done and is not counted as retired.
        if (r_ir == HALT_WORD) begin
          w_state_next = StHalt;
        end else if (done) begin
          w_retired_next = r_retired + RET_W'(1);
          if (r_pc != LAST_ADDR) begin
            w_pc_next    = r_pc + ADDR_W'(1);
            w_state_next = StFetch;
          end else begin
`ifdef FETCH_LOOP_EN
            w_pc_next    = '0;
            w_state_next = StFetch;
`else
            w_state_next = StHalt;
`endif
          end
        end
      end
      default: w_state_next = StIdle;
    endcase
  end

  assign iin       = (r_state == StExec) ? r_ir : '0;
  assign iin_valid = (r_state == StExec);
  assign halted    = (r_state == StHalt);
  assign pc        = r_pc;
  assign retired   = r_retired;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed self-checking bench for instruction_fetch; honours FETCH_LOOP_EN if defined.
module tb_instruction_fetch;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic        done;
  logic        load_en;
  logic [3:0]  load_addr;
  logic [15:0] load_data;
  logic [15:0] iin;
  logic        iin_valid;
  logic [3:0]  pc;
  logic        halted;
  logic [7:0]  retired;

  int n_checks = 0;
  int n_errors = 0;

  instruction_fetch u_dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .done      (done),
    .load_en   (load_en),
    .load_addr (load_addr),
    .load_data (load_data),
    .iin       (iin),
    .iin_valid (iin_valid),
    .pc        (pc),
    .halted    (halted),
    .retired   (retired)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled on the falling edge.
  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic load_word(input logic [3:0] a, input logic [15:0] d);
    load_en   = 1'b1;
    load_addr = a;
    load_data = d;
    tick();
    load_en   = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  // From EXEC: retire current instruction and land in EXEC on the next one.
  task automatic retire_one();
    done = 1'b1;
    tick();
    done = 1'b0;
    tick();
  endtask

  task automatic start_run();
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
  endtask

  initial begin
    logic stable;
    reset = 1'b0; start = 1'b0; done = 1'b0;
    load_en = 1'b0; load_addr = '0; load_data = '0;
    @(negedge clock);
    do_reset();
    check_eq("rst_iin", 32'(iin), 32'h0);
    check_eq("rst_valid", 32'(iin_valid), 32'h0);
    check_eq("rst_pc", 32'(pc), 32'h0);
    check_eq("rst_halted", 32'(halted), 32'h0);
    check_eq("rst_retired", 32'(retired), 32'h0);

    load_word(4'd0, 16'h1234);
    load_word(4'd1, 16'h5678);
    load_word(4'd2, 16'hFFFF);
    load_word(4'd7, 16'h7777);
    done = 1'b1;
    tick();
    done = 1'b0;
    check_eq("idle_done_ignored", 32'(retired), 32'h0);

    // Start raised before edge N+1; FETCH after it, EXEC after edge N+2.
    start = 1'b1;
    tick();
    start = 1'b0;
    check_eq("fetch_not_valid", 32'(iin_valid), 32'h0);
    tick();
    check_eq("exec0_valid", 32'(iin_valid), 32'h1);
    check_eq("exec0_iin", 32'(iin), 32'h1234);

    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (iin_valid !== 1'b1 || iin !== 16'h1234 || pc !== 4'd0) stable = 1'b0;
    end
    check_eq("hold_stable", 32'(stable), 32'h1);

    done = 1'b1;
    tick();
    done = 1'b0;
    check_eq("after_done_fetch", 32'(iin_valid), 32'h0);
    check_eq("after_done_retired", 32'(retired), 32'h1);
    tick();
    check_eq("exec1_iin", 32'(iin), 32'h5678);
    check_eq("exec1_pc", 32'(pc), 32'h1);

    retire_one();
    check_eq("exec2_iin", 32'(iin), 32'hFFFF);
    // Halt word with done and start both high: halt, no retire, start ignored.
    done = 1'b1; start = 1'b1;
    tick();
    done = 1'b0; start = 1'b0;
    check_eq("halt_halted", 32'(halted), 32'h1);
    check_eq("halt_retired", 32'(retired), 32'h2);
    check_eq("halt_pc", 32'(pc), 32'h2);
    check_eq("halt_valid", 32'(iin_valid), 32'h0);
    check_eq("halt_iin", 32'(iin), 32'h0);

    done = 1'b1;
    tick();
    done = 1'b0;
    check_eq("halt_done_ignored", 32'(retired), 32'h2);

    // Write and restart on the same edge: the fetch must see the new word.
    load_en = 1'b1; load_addr = 4'd0; load_data = 16'h4321; start = 1'b1;
    tick();
    load_en = 1'b0; start = 1'b0;
    tick();
    check_eq("restart_iin", 32'(iin), 32'h4321);
    check_eq("restart_pc", 32'(pc), 32'h0);
    check_eq("restart_retired", 32'(retired), 32'h2);

    load_word(4'd7, 16'hAAAA);
    check_eq("exec_load_stays", 32'(iin), 32'h4321);
    do_reset();
    check_eq("rst_exec_valid", 32'(iin_valid), 32'h0);
    check_eq("rst_exec_retired", 32'(retired), 32'h0);

    for (int i = 0; i < 7; i++) load_word(4'(i), 16'h0100 + 16'(i));
    start_run();
    for (int i = 0; i < 5; i++) retire_one();
    check_eq("pc5_iin", 32'(iin), 32'h0105);
    check_eq("pc5_pc", 32'(pc), 32'h5);
    do_reset();
    check_eq("rst_pc5_pc", 32'(pc), 32'h0);
    check_eq("rst_pc5_valid", 32'(iin_valid), 32'h0);
    check_eq("rst_pc5_retired", 32'(retired), 32'h0);
    start_run();
    check_eq("rerun_iin", 32'(iin), 32'h0100);
    for (int i = 0; i < 7; i++) retire_one();
    check_eq("mem7_kept", 32'(iin), 32'h7777);
    check_eq("mem7_retired", 32'(retired), 32'h7);

    do_reset();
    for (int i = 0; i < 16; i++) load_word(4'(i), 16'h0001);
    start_run();
    for (int k = 0; k < 16; k++) begin
      check_eq($sformatf("fill_pc%0d", k), 32'(pc), 32'(k));
      check_eq($sformatf("fill_iin%0d", k), 32'(iin), 32'h1);
      done = 1'b1;
      tick();
      done = 1'b0;
      if (k < 15) tick();
    end
`ifdef FETCH_LOOP_EN
    tick();
    check_eq("wrap_pc", 32'(pc), 32'h0);
    check_eq("wrap_iin", 32'(iin), 32'h1);
    check_eq("wrap_retired", 32'(retired), 32'h10);
`else
    check_eq("end_halted", 32'(halted), 32'h1);
    check_eq("end_retired", 32'(retired), 32'h10);
    check_eq("end_pc", 32'(pc), 32'hF);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
